// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard / halt / single-step controller.
//
// Detects load-use hazards between EXE and ID, flushes IFID on taken
// branches, and runs a small debug FSM: a decoded halt drains the pipeline
// for DRAIN_CYCLES bubble cycles, then parks in HALTED until the debug host
// asks to resume (run_req) or to execute one instruction (step_req).
//
// Parameters:
//   DRAIN_CYCLES  bubble cycles spent emptying ID/EXE/MEM/WB (1..15)
//   PERF_W        width of each performance counter
//
// Optional feature: define PIPE_CTRL_PERF_EN to add the performance
// counters cyc_cnt, stall_cnt and flush_cnt.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   id_rs, id_rt          source fields of the instruction in ID
//   id_uses_rt            ID instruction reads rt
//   ex_destReg            destination register of the instruction in EXE
//   ex_wreg, ex_m2reg     EXE instruction writes the regfile / is a load
//   br_taken              branch or jump resolved taken in ID
//   halt_req              halt instruction decoded in ID
//   run_req, step_req     debug host requests (honoured only in HALTED)
//   pc_we, ifid_we        PC / IFID write enables
//   ifid_flush            load a NOP into IFID on the next edge
//   idexe_bubble          zero the IDEXE control bits
//   halted                controller is in HALTED
//   state                 current FSM state (RUN=0 DRAIN=1 HALTED=2 STEP=3)
//   cyc_cnt, stall_cnt, flush_cnt  (PIPE_CTRL_PERF_EN only)
//
// There is no valid/ready handshake here: every output is a per-cycle
// level that the datapath samples on the same rising edge.
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int PERF_W       = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_destReg,
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic       br_taken,
  input  logic       halt_req,
  input  logic       run_req,
  input  logic       step_req,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idexe_bubble,
  output logic       halted,
  output logic [2:0] state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cyc_cnt,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_HALTED = 3'd2,
    ST_STEP   = 3'd3
  } state_t;

  // The drain counter is loaded with DRAIN_CYCLES-1 and the FSM leaves
  // DRAIN on the cycle it reads 0, so DRAIN lasts exactly DRAIN_CYCLES.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || PERF_W < 1) begin : g_bad_param
    $error("pipe_ctrl: DRAIN_CYCLES must be 1..15 and PERF_W >= 1");
  end

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       stall;

  assign state = state_q;

  assign load_use = ex_m2reg & ex_wreg & (ex_destReg != 5'd0) &
                    ((ex_destReg == id_rs) | (id_uses_rt & (ex_destReg == id_rt)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b1;
    halted       = 1'b0;
    stall        = 1'b0;

    case (state_q)
      // STEP behaves exactly like RUN for one cycle, then falls back to
      // HALTED unless that instruction was itself a halt.
      ST_RUN, ST_STEP: begin
        if (load_use) begin
          // Load-use beats branch and halt: freeze PC/IFID, bubble IDEXE.
          stall   = 1'b1;
          state_d = (state_q == ST_STEP) ? ST_HALTED : ST_RUN;
        end else if (halt_req) begin
          // The halt itself issues down the pipe; the instruction fetched
          // behind it is squashed and the PC frozen.
          ifid_we      = 1'b1;
          ifid_flush   = 1'b1;
          idexe_bubble = 1'b0;
          cnt_d        = DRAIN_LOAD;
          state_d      = ST_DRAIN;
        end else begin
          pc_we        = 1'b1;
          ifid_we      = 1'b1;
          ifid_flush   = br_taken;
          idexe_bubble = 1'b0;
          state_d      = (state_q == ST_STEP) ? ST_HALTED : ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 4'd0) state_d = ST_HALTED;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (run_req)       state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      default: state_d = ST_RUN;
    endcase

    // Reset overrides everything so the datapath sees a quiet pipeline.
    if (reset) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b0;
      idexe_bubble = 1'b1;
      halted       = 1'b0;
      stall        = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Counters wrap naturally from all-ones to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (stall)      stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule
